// File: rtl/sram_mem_ctrl.sv
// MEM-stage data-memory controller: each 32-bit load/store becomes two 16-bit SRAM phases with wait states.
// Define SRAM_LAST_READ_BUF_EN to add a one-entry last-read buffer that short-circuits repeated loads.
module sram_mem_ctrl #(
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int          WAIT_CYCLES = 2,
   parameter int          SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_dq_oe,
   output logic               sram_we_n
);
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             op_wr;
   logic [29:0]      lat_idx;
   logic [31:0]      lat_wdata;
   logic [31:0]      offset;
   logic [29:0]      req_idx;
   logic             req;
   logic             hit;
   logic             start;
   logic             cnt_done;
   logic             rd_fill;
   logic [31:0]      hit_data;
   logic             unused_ok;

   assign offset   = address - BASE_ADDR;
   assign req_idx  = offset[31:2];
   assign req      = wr_en | rd_en;
   assign start    = (state == IDLE) & req & ~hit;
   assign cnt_done = (cnt == CNT_LAST);
   assign rd_fill  = (state == HIGH) & cnt_done & ~op_wr;
   assign ready    = (state == DONE) | ((state == IDLE) & (~req | hit));
   assign unused_ok = &{1'b0, offset[1:0], lat_idx[29:SRAM_AW-1]};

`ifdef SRAM_LAST_READ_BUF_EN
   logic        buf_vld;
   logic [29:0] buf_idx;
   logic [31:0] buf_data;

   assign hit      = buf_vld & rd_en & ~wr_en & (buf_idx == req_idx);
   assign hit_data = buf_data;

   // Any accepted store may alias the buffered word, so it simply invalidates the entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_vld <= 1'b0;
      end else if ((state == IDLE) && wr_en) begin
         buf_vld <= 1'b0;
      end else if (rd_fill) begin
         buf_vld <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_fill) begin
         buf_idx  <= lat_idx;
         buf_data <= {sram_dq_in, read_data[15:0]};
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_data = read_data;
`endif

   // Request operands are captured once in IDLE; later changes on the inputs are ignored.
   always_ff @(posedge clk) begin
      if (start) begin
         lat_idx   <= req_idx;
         lat_wdata <= write_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         op_wr       <= 1'b0;
         read_data   <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= LOW;
                  cnt       <= '0;
                  op_wr     <= wr_en;
                  sram_addr <= {req_idx[SRAM_AW-2:0], 1'b0};
                  if (wr_en) begin
                     sram_dq_out <= write_data[15:0];
                     sram_dq_oe  <= 1'b1;
                     sram_we_n   <= 1'b0;
                  end
               end else if (hit) begin
                  read_data <= hit_data;
               end
            end
            LOW: begin
               if (cnt_done) begin
                  state     <= HIGH;
                  cnt       <= '0;
                  sram_addr <= {lat_idx[SRAM_AW-2:0], 1'b1};
                  if (op_wr) begin
                     sram_dq_out <= lat_wdata[31:16];
                  end else begin
                     read_data[15:0] <= sram_dq_in;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HIGH: begin
               if (cnt_done) begin
                  state      <= DONE;
                  cnt        <= '0;
                  sram_dq_oe <= 1'b0;
                  sram_we_n  <= 1'b1;
                  if (!op_wr) begin
                     read_data[31:16] <= sram_dq_in;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Scoreboard bench for sram_mem_ctrl: a driver queues expected completions, a monitor checks them.
// The reference keeps whole 32-bit words per index and derives latency/buffer hits from the access rules.
module tb_sram_mem_ctrl;
   localparam logic [31:0] BASE = 32'd1024;
   localparam int WC  = 2;
   localparam int AW  = 18;
   localparam int LAT = 2 * WC + 1;
`ifdef SRAM_LAST_READ_BUF_EN
   localparam bit BUF_EN = 1'b1;
`else
   localparam bit BUF_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [31:0]   address = '0;
   logic [31:0]   write_data = '0;
   logic [31:0]   read_data;
   logic          ready;
   logic [AW-1:0] sram_addr;
   logic [15:0]   sram_dq_out;
   logic [15:0]   sram_dq_in;
   logic          sram_dq_oe;
   logic          sram_we_n;

   sram_mem_ctrl #(.BASE_ADDR(BASE), .WAIT_CYCLES(WC), .SRAM_AW(AW)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
      .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n));

   initial forever #5 clk = ~clk;

   function automatic logic [15:0] init_hw(input int i);
      return 16'(i * 40503 + 4951);
   endfunction

   // external SRAM device
   logic [15:0] sram_mem [0:63];
   logic        mem_init = 1'b1;
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) sram_mem[i] <= init_hw(i);
      end else if (!sram_we_n) begin
         sram_mem[sram_addr[5:0]] <= sram_dq_out;
      end
   end
   assign sram_dq_in = sram_mem[sram_addr[5:0]];

   typedef struct {
      bit          is_wr;
      bit          abort;
      int          idx;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          lat;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_mis = 0;

   logic [31:0] m_word [0:15];
   logic [31:0] m_last = '0;
   bit          m_buf_v = 1'b0;
   int          m_buf_idx = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // monitor: pops an expectation when a request is accepted, checks bus phases and completion
   initial begin
      bit   busy;
      int   k;
      bit   half;
      exp_t cur;
      busy = 1'b0;
      k = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy = 1'b0;
         end else begin
            if (busy) begin
               k++;
               if (k <= 2 * WC) begin
                  half = (k > WC);
                  check("ready_low", 32'(ready), 32'd0);
                  check("sram_addr", 32'(sram_addr), 32'(cur.idx * 2 + int'(half)));
                  if (cur.is_wr) begin
                     check("we_n_wr", 32'(sram_we_n), 32'd0);
                     check("oe_wr", 32'(sram_dq_oe), 32'd1);
                     check("dq_out", 32'(sram_dq_out), half ? 32'(cur.wdata[31:16]) : 32'(cur.wdata[15:0]));
                  end else begin
                     check("we_n_rd", 32'(sram_we_n), 32'd1);
                     check("oe_rd", 32'(sram_dq_oe), 32'd0);
                  end
               end
            end else if (wr_en || rd_en) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_mis++;
                  $display("FAIL accept: got unexpected request, expected none pending");
               end else begin
                  cur = exp_q.pop_front();
                  busy = 1'b1;
                  k = 0;
               end
            end
            if (busy && ready) begin
               check("latency", 32'(k), 32'(cur.lat));
               check("read_data", read_data, cur.rdata);
               check("we_n_done", 32'(sram_we_n), 32'd1);
               check("oe_done", 32'(sram_dq_oe), 32'd0);
               if (cur.is_wr) begin
                  check("mem_lo", 32'(sram_mem[cur.idx * 2]), 32'(cur.wdata[15:0]));
                  check("mem_hi", 32'(sram_mem[cur.idx * 2 + 1]), 32'(cur.wdata[31:16]));
               end
               busy = 1'b0;
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         wr_en = 1'b0;
         rd_en = 1'b0;
      end
   endtask

   task automatic issue(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d, input bit hold);
      exp_t e;
      int   idx;
      int   n;
      bit   hit;
      idx = int'((a - BASE) >> 2);
      e.is_wr = w;
      e.abort = 1'b0;
      e.idx   = idx;
      e.wdata = d;
      e.lat   = LAT;
      if (w) begin
         m_word[idx] = d;
         m_buf_v = 1'b0;
         e.rdata = m_last;
      end else begin
         hit = BUF_EN && m_buf_v && (m_buf_idx == idx);
         e.rdata = m_word[idx];
         m_last = m_word[idx];
         if (hit) begin
            e.lat = 0;
         end else begin
            m_buf_v = 1'b1;
            m_buf_idx = idx;
         end
      end
      @(posedge clk); #1;
      wr_en = w;
      rd_en = r;
      address = a;
      write_data = d;
      exp_q.push_back(e);
      if (!hold) begin
         @(posedge clk); #1;
         wr_en = 1'b0;
         rd_en = 1'b0;
         address = $urandom;
         write_data = $urandom;
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ready && n < 64);
      check("ready_timeout", 32'(ready), 32'd1);
   endtask

   // store to word idx, asynchronous reset lands in the first HIGH cycle
   task automatic reset_abort(input int idx, input logic [31:0] d);
      exp_t e;
      e.is_wr = 1'b1;
      e.abort = 1'b1;
      e.idx   = idx;
      e.wdata = d;
      e.rdata = '0;
      e.lat   = -1;
      @(posedge clk); #1;
      wr_en = 1'b1;
      rd_en = 1'b0;
      address = BASE + 32'(idx * 4);
      write_data = d;
      exp_q.push_back(e);
      @(posedge clk); #1;
      wr_en = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_we_n", 32'(sram_we_n), 32'd1);
      check("abort_oe", 32'(sram_dq_oe), 32'd0);
      check("abort_read_data", read_data, 32'd0);
      check("abort_ready", 32'(ready), 32'd1);
      check("abort_sram_addr", 32'(sram_addr), 32'd0);
      m_word[idx] = {m_word[idx][31:16], d[15:0]};
      m_last = '0;
      m_buf_v = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int          op;
      int          idx;
      logic [31:0] a;
      for (int i = 0; i < 16; i++) m_word[i] = {init_hw(2 * i + 1), init_hw(2 * i)};
      repeat (3) @(negedge clk);
      mem_init = 1'b0;
      rst = 1'b0;
      #1;
      check("rst_read_data", read_data, 32'd0);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_we_n", 32'(sram_we_n), 32'd1);
      check("rst_oe", 32'(sram_dq_oe), 32'd0);
      check("rst_sram_addr", 32'(sram_addr), 32'd0);
      check("rst_dq_out", 32'(sram_dq_out), 32'd0);

      issue(1'b1, 1'b0, BASE, 32'hDEADBEEF, 1'b1);
      issue(1'b0, 1'b1, BASE, 32'h0, 1'b0);
      issue(1'b1, 1'b0, BASE + 32'd12, 32'h12345678, 1'b1);
      issue(1'b0, 1'b1, BASE + 32'd14, 32'h0, 1'b1);
      issue(1'b1, 1'b1, BASE + 32'd4, 32'hA5A55A5A, 1'b0);
      issue(1'b0, 1'b1, BASE, 32'h0, 1'b1);
      issue(1'b0, 1'b1, BASE + 32'd2, 32'h0, 1'b0);
      issue(1'b1, 1'b0, BASE, 32'hCAFEF00D, 1'b0);
      issue(1'b0, 1'b1, BASE, 32'h0, 1'b1);
      idle(2);
      reset_abort(3, 32'h0BADF00D);
      issue(1'b1, 1'b0, BASE + 32'd8, 32'h13579BDF, 1'b1);
      issue(1'b0, 1'b1, BASE + 32'd13, 32'h0, 1'b0);
      idle(1);

      for (int t = 0; t < 300; t++) begin
         op  = int'($urandom_range(0, 9));
         idx = int'($urandom_range(0, 15));
         a   = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
         issue(op >= 4, (op < 4) || (op >= 8), a, $urandom, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end
      idle(3);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- MEM-stage data-memory controller; sits between EX/MEM pipeline register outputs and the MEM/WB stage register.
- Converts single-cycle 32-bit load/store requests into two 16-bit accesses on external SRAM with programmable wait states.
- Drives `ready` low to freeze the pipeline until the access completes; `read_data` feeds the MEM/WB register's memory-read-value input.

Parameters:
- BASE_ADDR, 1024, byte address mapped to SRAM word 0
- WAIT_CYCLES, 2, clock cycles each halfword phase is held on the bus (>=1)
- SRAM_AW, 18, SRAM halfword address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  store request from EX/MEM
- rd_en  in  1  load request from EX/MEM
- address  in  32  byte address (ALU result)
- write_data  in  32  store data (Val_Rm)
- read_data  out  32  assembled load data
- ready  out  1  1 = no access pending or access complete; 0 = freeze pipeline
- sram_addr  out  SRAM_AW  halfword address
- sram_dq_out  out  16  write data to SRAM
- sram_dq_in  in  16  read data from SRAM
- sram_dq_oe  out  1  1 = controller drives DQ
- sram_we_n  out  1  active-low write strobe

Behaviour:
- Reset: state IDLE, counter 0, read_data 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_we_n 1. Reset mid-access aborts immediately with no completion.
- Address map:
  - word index = (address - BASE_ADDR) >> 2, modulo 32-bit wrap
  - low half at sram_addr = {index, 0}; high half at {index, 1}, truncated to SRAM_AW bits
  - address[1:0] ignored
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if wr_en or rd_en, latch op, address, write_data; go to LOW; counter = 0.
  - LOW: hold low-half address for WAIT_CYCLES cycles; counter increments each cycle; at counter == WAIT_CYCLES-1 go to HIGH, counter = 0.
  - HIGH: same as LOW for the high half; then go to DONE.
  - DONE: one cycle, then IDLE.
- ready = (state == DONE) or (state == IDLE and not (wr_en or rd_en)). ready is combinational from state and request.
- Latency: request seen in IDLE at cycle 0 gives ready=0 in cycles 0..2*WAIT_CYCLES and ready=1 at cycle 2*WAIT_CYCLES+1 (cycle 5 for default).
- Write:
  - sram_dq_oe=1 and sram_we_n=0 throughout LOW and HIGH.
  - sram_dq_out = write_data[15:0] in LOW, write_data[31:16] in HIGH.
  - sram_we_n returns to 1 in DONE.
- Read:
  - sram_dq_oe=0 and sram_we_n=1.
  - sram_dq_in sampled on the last cycle of LOW into read_data[15:0], and on the last cycle of HIGH into read_data[31:16].
  - read_data is stable from DONE until the next read completes.
- wr_en and rd_en both high: treated as a write.
- Request inputs change or drop after IDLE: ignored; the latched operation runs to completion.
- Request still asserted in DONE: not a new access. Pipeline advances on ready=1; the next request is accepted from IDLE the following cycle.
- Back-to-back requests: IDLE occupies exactly one cycle between accesses.

Optional Feature:
- Macro: SRAM_LAST_READ_BUF_EN
- Defined:
  - A one-entry buffer holds the last read word index and data, plus a valid bit.
  - Valid bit is cleared on reset and on any write.
  - A read in IDLE whose word index matches a valid entry completes with ready=1 in the same cycle, read_data = buffered data, and no SRAM activity.
  - Reads that complete through DONE update the buffer.
- Undefined: every read performs the full LOW/HIGH SRAM sequence; no buffer logic is present.

Test Plan:
- Write then read, WAIT_CYCLES=2: wr_en, address=1024, write_data=0xDEADBEEF
  - SRAM model gets 0xBEEF at addr 0 and 0xDEAD at addr 1; ready low in cycles 0-4, high in cycle 5.
  - Subsequent rd_en at 1024 gives read_data=0xDEADBEEF at DONE.
- Address mapping: write 0x12345678 to address 1036
  - SRAM halfwords 6 = 0x5678 and 7 = 0x1234; address 1038 maps to the same word.
- Request dropped mid-access: rd_en pulsed for 1 cycle only
  - Access still completes, ready=1 at cycle 5, data is correct.
- Reset mid-access: rst asserted during HIGH of a write
  - Immediately state IDLE, sram_we_n=1, sram_dq_oe=0, read_data=0; next request starts cleanly.
- Simultaneous rd_en=wr_en=1 at address 1028, write_data=0xA5A5_5A5A
  - Write performed with we_n low; read_data unchanged.
- With SRAM_LAST_READ_BUF_EN defined:
  - Second read of 1024 gives ready=1 in cycle 0, no SRAM write or address change.
  - After an intervening write to 1024, the next read takes the full 5 cycles.
